// File: rtl/core_bus_pkg.sv
// Shared types and sizing helpers for the Wishbone bus arbiter.
package core_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ERROR = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Width of an index into n masters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value t without wrapping.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

  // Round-robin candidate: position k after pointer ptr, modulo n.
  function automatic int rr_index(input int ptr, input int k, input int n);
    int s;
    s = ptr + k;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first active request at or after ptr_i.
module rr_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic found;

  // Scan requests starting at the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[IDX_W'(rr_index(int'(ptr_i), k, NUM_REQ))]) begin
        found = 1'b1;
        idx_o = IDX_W'(rr_index(int'(ptr_i), k, NUM_REQ));
        gnt_o[IDX_W'(rr_index(int'(ptr_i), k, NUM_REQ))] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Multi-master Wishbone arbiter with round-robin grant, bus lock while cyc is
// held, and a stall timeout that aborts the cycle with a one-cycle error.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MASTERS-1:0]           m_cyc_i,
  input  logic [NUM_MASTERS-1:0]           m_stb_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_data_o,
  input  logic [DATA_WIDTH-1:0]            s_data_i,
  input  logic                             s_ack_i,
  output logic [NUM_MASTERS-1:0]           grant_o
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  // Counter value on the stalled cycle that completes the timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] rr_gnt;
  logic [IDX_W-1:0]       rr_idx;
  logic                   rr_valid;
  logic                   owner_cyc;
  logic                   owner_stb;
  logic                   stall;
  logic                   timeout_hit;
  logic [IDX_W-1:0]       next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (m_cyc_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  assign owner_cyc = m_cyc_i[owner_q];
  assign owner_stb = m_stb_i[owner_q];
  // A stall is an owned cycle with the strobe up and no ack yet; an ack on
  // the would-be final stall cycle is therefore not a stall and wins.
  assign stall       = (state_q == ST_OWNED) && owner_stb && !s_ack_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && stall && (cnt_q == CNT_LAST);
  assign next_ptr    = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
  assign grant_o     = grant_q;

  // State, grant, owner, round-robin pointer and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: grant in IDLE, hold while owner keeps cyc, abort on timeout.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          state_d = ST_OWNED;
          grant_d = rr_gnt;
          owner_d = rr_idx;
          cnt_d   = '0;
        end
      end
      ST_OWNED: begin
        if (!owner_cyc) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (stall && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        rr_ptr_d = next_ptr;
        cnt_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output mux: downstream follows the owner only while OWNED; error pulse in ERROR.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_data_o = '0;
    if (state_q == ST_OWNED) begin
      s_cyc_o          = owner_cyc;
      s_stb_o          = owner_stb;
      s_we_o           = m_we_i[owner_q];
      s_addr_o         = m_addr_i[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
      s_data_o         = m_data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
      m_ack_o[owner_q] = s_ack_i;
      m_data_o         = s_data_i;
    end
    if (state_q == ST_ERROR) begin
      m_err_o[owner_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_core_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_data;
  logic [DW-1:0] m_data_o;
  logic [N-1:0]  m_ack, m_err, grant;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data_o;
  logic [DW-1:0] s_data_i;
  logic          s_ack;

  int n_checks = 0;
  int n_fail   = 0;

  core_bus_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_data_i (m_data),
    .m_data_o (m_data_o),
    .m_ack_o  (m_ack),
    .m_err_o  (m_err),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_addr_o (s_addr),
    .s_data_o (s_data_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack),
    .grant_o  (grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_data = '0;
    s_ack = 1'b0; s_data_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_cyc = '1; m_stb = '1; m_we = '1; m_addr = '1; m_data = '1;
    s_ack = 1'b1; s_data_i = 32'h1234_5678;
    tick();
    tick();
    #2;
    n_checks++;
    if (grant !== '0) begin n_fail++; $display("FAIL reset_grant got %h want 0", grant); end
    n_checks++;
    if ({s_cyc, s_stb, s_we, s_addr, s_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_sbus got %b%b%b %h %h want all 0", s_cyc, s_stb, s_we, s_addr, s_data_o);
    end
    n_checks++;
    if (m_ack !== '0 || m_err !== '0) begin n_fail++; $display("FAIL reset_ack_err got ack %b err %b want 0", m_ack, m_err); end
    n_checks++;
    if (m_data_o !== '0) begin n_fail++; $display("FAIL reset_mdata got %h want 0", m_data_o); end
    do_reset();
  endtask

  // Two masters request together: 0 first, then 1 after one idle cycle.
  task automatic test_grant_order();
    do_reset();
    m_cyc = 4'b0011;
    #2;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL order_idle got %b want 0000", grant); end
    tick();
    #2;
    n_checks++;
    if (grant !== 4'b0001 || s_cyc !== 1'b1) begin n_fail++; $display("FAIL order_first got grant %b cyc %b want 0001 1", grant, s_cyc); end
    m_cyc = 4'b0010;
    tick();
    #2;
    n_checks++;
    if (grant !== 4'b0000 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL order_gap got grant %b cyc %b want 0000 0", grant, s_cyc); end
    tick();
    #2;
    n_checks++;
    if (grant !== 4'b0010 || s_cyc !== 1'b1) begin n_fail++; $display("FAIL order_second got grant %b cyc %b want 0010 1", grant, s_cyc); end
    m_cyc = '0;
    tick();
  endtask

  // Master 1 locks the bus over three strobes while master 0 waits.
  task automatic test_lock();
    logic [AW-1:0] addrs [3];
    addrs[0] = 16'h0010; addrs[1] = 16'h0014; addrs[2] = 16'h0018;
    do_reset();
    m_cyc = 4'b0010;
    tick();
    for (int i = 0; i < 3; i++) begin
      m_cyc = 4'b0011;
      m_stb = 4'b0010;
      m_addr[1*AW +: AW] = addrs[i];
      s_ack = 1'b1;
      s_data_i = 32'hA000_0000 + i;
      #2;
      n_checks++;
      if (grant !== 4'b0010) begin n_fail++; $display("FAIL lock_grant[%0d] got %b want 0010", i, grant); end
      n_checks++;
      if (m_ack !== 4'b0010) begin n_fail++; $display("FAIL lock_ack[%0d] got %b want 0010", i, m_ack); end
      n_checks++;
      if (s_addr !== addrs[i]) begin n_fail++; $display("FAIL lock_addr[%0d] got %h want %h", i, s_addr, addrs[i]); end
      tick();
      m_stb = '0;
      s_ack = 1'b0;
      #2;
      n_checks++;
      if (grant !== 4'b0010 || m_ack[0] !== 1'b0) begin n_fail++; $display("FAIL lock_hold[%0d] got grant %b ack %b want 0010 0", i, grant, m_ack); end
      tick();
    end
    m_cyc = '0;
    tick();
  endtask

  // Four stalled cycles abort the transfer; the other master is served next.
  task automatic test_timeout();
    do_reset();
    m_cyc = 4'b0011;
    m_stb = 4'b0001;
    s_ack = 1'b0;
    tick();
    for (int k = 1; k <= T; k++) begin
      #2;
      n_checks++;
      if (m_err !== 4'b0000 || s_cyc !== 1'b1) begin n_fail++; $display("FAIL timeout_stall[%0d] got err %b cyc %b want 0000 1", k, m_err, s_cyc); end
      tick();
    end
    #2;
    n_checks++;
    if (m_err !== 4'b0001) begin n_fail++; $display("FAIL timeout_err got %b want 0001", m_err); end
    n_checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_fail++; $display("FAIL timeout_scyc got cyc %b stb %b want 0 0", s_cyc, s_stb); end
    tick();
    #2;
    n_checks++;
    if (m_err !== 4'b0000 || grant !== 4'b0000) begin n_fail++; $display("FAIL timeout_idle got err %b grant %b want 0000 0000", m_err, grant); end
    tick();
    #2;
    n_checks++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL timeout_next got %b want 0010", grant); end
    m_cyc = '0; m_stb = '0;
    tick();
  endtask

  // Ack on the last stalled cycle is delivered and no error follows.
  task automatic test_ack_wins();
    do_reset();
    m_cyc = 4'b0001;
    m_stb = 4'b0001;
    s_ack = 1'b0;
    tick();
    for (int k = 1; k < T; k++) tick();
    s_ack = 1'b1;
    s_data_i = 32'h0BAD_F00D;
    #2;
    n_checks++;
    if (m_ack !== 4'b0001 || m_err !== 4'b0000) begin n_fail++; $display("FAIL ackwin_ack got ack %b err %b want 0001 0000", m_ack, m_err); end
    tick();
    s_ack = 1'b0;
    #2;
    n_checks++;
    if (m_err !== 4'b0000 || grant !== 4'b0001) begin n_fail++; $display("FAIL ackwin_after got err %b grant %b want 0000 0001", m_err, grant); end
    m_cyc = '0; m_stb = '0;
    tick();
  endtask

  // Four masters, single-strobe cycles: grant order 0,1,2,3,0.
  task automatic test_rr4();
    logic [N-1:0] exp_g;
    int budget;
    int idx;
    do_reset();
    m_cyc = 4'hF;
    m_stb = 4'hF;
    s_ack = 1'b0;
    s_data_i = 32'hCAFEBABE;
    for (int k = 0; k < 5; k++) begin
      idx = k % N;
      exp_g = N'(1) << idx;
      budget = 0;
      #2;
      while (grant === '0 && budget < 6) begin
        tick();
        #2;
        budget++;
      end
      n_checks++;
      if (grant !== exp_g) begin n_fail++; $display("FAIL rr4_grant[%0d] got %b want %b", k, grant, exp_g); end
      s_ack = 1'b1;
      #1;
      n_checks++;
      if (m_data_o !== 32'hCAFEBABE || m_ack !== exp_g) begin
        n_fail++; $display("FAIL rr4_data[%0d] got data %h ack %b want cafebabe %b", k, m_data_o, m_ack, exp_g);
      end
      tick();
      m_cyc[2'(idx)] = 1'b0;
      s_ack = 1'b0;
      tick();
      m_cyc[2'(idx)] = 1'b1;
    end
    m_cyc = '0; m_stb = '0;
    tick();
  endtask

  // Reset during OWNED clears outputs at once; arbitration restarts at 0.
  task automatic test_reset_mid();
    do_reset();
    m_cyc = 4'b0100;
    tick();
    m_cyc = 4'hF;
    m_stb = 4'hF;
    s_ack = 1'b1;
    s_data_i = 32'h5555_AAAA;
    #2;
    n_checks++;
    if (grant !== 4'b0100 || m_ack !== 4'b0100) begin n_fail++; $display("FAIL rstmid_pre got grant %b ack %b want 0100 0100", grant, m_ack); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== '0 || m_ack !== '0 || m_err !== '0 || m_data_o !== '0 ||
        {s_cyc, s_stb, s_we, s_addr, s_data_o} !== '0) begin
      n_fail++; $display("FAIL rstmid_async got grant %b ack %b cyc %b data %h want all 0", grant, m_ack, s_cyc, m_data_o);
    end
    tick();
    rst_n = 1'b1;
    s_ack = 1'b0;
    #2;
    n_checks++;
    if (grant !== '0 || m_ack !== '0) begin n_fail++; $display("FAIL rstmid_idle got grant %b ack %b want 0000 0000", grant, m_ack); end
    tick();
    #2;
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_restart got %b want 0001", grant); end
    m_cyc = '0; m_stb = '0;
    tick();
  endtask

  // Random traffic versus a transaction-level model of ownership.
  task automatic test_random();
    int owner;      // -1 when nobody owns the bus
    bit aborting;   // owner's cycle is being aborted this cycle
    int ptr;
    int stalls;
    bit found;
    int c;
    logic [N-1:0] flip;
    logic [N-1:0] e_grant, e_ack, e_err;
    logic [DW-1:0] e_mdata;
    logic [2+AW+DW:0] e_bus, a_bus;
    do_reset();
    owner = -1; aborting = 1'b0; ptr = 0; stalls = 0;
    for (int cyc_n = 0; cyc_n < 800; cyc_n++) begin
      flip = N'($urandom) & N'($urandom);
      m_cyc = m_cyc ^ flip;
      m_stb = N'($urandom);
      m_we = N'($urandom);
      for (int i = 0; i < N; i++) begin
        m_addr[i*AW +: AW] = AW'($urandom);
        m_data[i*DW +: DW] = $urandom;
      end
      s_ack = ($urandom_range(0, 9) < 3);
      s_data_i = $urandom;
      #2;
      e_grant = '0; e_ack = '0; e_err = '0; e_mdata = '0; e_bus = '0;
      if (owner >= 0) e_grant = N'(1) << owner;
      if (owner >= 0 && !aborting) begin
        e_bus = {m_cyc[2'(owner)], m_stb[2'(owner)], m_we[2'(owner)],
                 m_addr[owner*AW +: AW], m_data[owner*DW +: DW]};
        e_ack = s_ack ? (N'(1) << owner) : '0;
        e_mdata = s_data_i;
      end
      if (owner >= 0 && aborting) e_err = N'(1) << owner;
      a_bus = {s_cyc, s_stb, s_we, s_addr, s_data_o};
      n_checks++;
      if (grant !== e_grant) begin n_fail++; $display("FAIL rand_grant@%0d got %b want %b", cyc_n, grant, e_grant); end
      n_checks++;
      if (a_bus !== e_bus) begin n_fail++; $display("FAIL rand_sbus@%0d got %h want %h", cyc_n, a_bus, e_bus); end
      n_checks++;
      if (m_ack !== e_ack || m_err !== e_err) begin
        n_fail++; $display("FAIL rand_ackerr@%0d got ack %b err %b want %b %b", cyc_n, m_ack, m_err, e_ack, e_err);
      end
      n_checks++;
      if (m_data_o !== e_mdata) begin n_fail++; $display("FAIL rand_mdata@%0d got %h want %h", cyc_n, m_data_o, e_mdata); end
      // advance the model by one clock
      if (owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          c = (ptr + k) % N;
          if (!found && m_cyc[2'(c)]) begin
            found = 1'b1;
            owner = c;
            stalls = 0;
          end
        end
      end else if (aborting) begin
        ptr = (owner + 1) % N;
        owner = -1;
        aborting = 1'b0;
      end else if (!m_cyc[2'(owner)]) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end else if (s_ack) begin
        stalls = 0;
      end else if (m_stb[2'(owner)]) begin
        stalls++;
        if (stalls == T) aborting = 1'b1;
      end
      tick();
    end
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    tick();
  endtask

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_data = '0;
    s_ack = 1'b0; s_data_i = '0;
    test_reset();
    test_grant_order();
    test_lock();
    test_timeout();
    test_ack_wins();
    test_rr4();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone master ports (legal 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles a strobe waits for ack; 0 disables the timeout.
REQ-005 SHALL have one clock and an asynchronous active-low reset, ports named clk and rst_n.
REQ-006 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port m_cyc_i, input, NUM_MASTERS, per-master cycle request.
REQ-009 SHALL have port m_stb_i, input, NUM_MASTERS, per-master strobe.
REQ-010 SHALL have port m_we_i, input, NUM_MASTERS, per-master write enable.
REQ-011 SHALL have port m_addr_i, input, NUM_MASTERS*ADDR_WIDTH, packed addresses, master i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port m_data_i, input, NUM_MASTERS*DATA_WIDTH, packed write data, same packing.
REQ-013 SHALL have port m_data_o, output, DATA_WIDTH, read data broadcast to all masters.
REQ-014 SHALL have port m_ack_o, output, NUM_MASTERS, per-master acknowledge.
REQ-015 SHALL have port m_err_o, output, NUM_MASTERS, per-master timeout error.
REQ-016 SHALL have ports s_cyc_o, s_stb_o, s_we_o (output, 1), s_addr_o (output, ADDR_WIDTH), s_data_o (output, DATA_WIDTH): downstream Wishbone master to the controller.
REQ-017 SHALL have ports s_data_i (input, DATA_WIDTH) and s_ack_i (input, 1): downstream response.
REQ-018 SHALL have port grant_o, output, NUM_MASTERS, one-hot current owner; all-zero when idle.

Function
REQ-019 SHALL implement states IDLE, OWNED, ERROR.
REQ-020 In IDLE with any m_cyc_i high, SHALL select a requester by round-robin starting at pointer rr_ptr and enter OWNED next edge with grant_o registered one-hot.
REQ-021 Grant latency SHALL be exactly one cycle from a request seen in IDLE to s_cyc_o high.
REQ-022 In OWNED, s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_data_o SHALL combinationally follow the granted master; all downstream outputs SHALL be 0 outside OWNED.
REQ-023 s_ack_i SHALL route combinationally to m_ack_o of the granted master only; other m_ack_o bits SHALL stay 0.
REQ-024 m_data_o SHALL equal s_data_i in OWNED and 0 otherwise.
REQ-025 Grant SHALL persist while the owner holds m_cyc_i high (bus lock across multiple strobes); requests from other masters SHALL not preempt.
REQ-026 When the owner drops m_cyc_i, SHALL return to IDLE next edge and set rr_ptr to owner index+1, wrapping NUM_MASTERS-1 to 0.
REQ-027 IDLE SHALL last at least one cycle between ownerships (no back-to-back handover).
REQ-028 Timeout counter SHALL clear on entry to OWNED and on every s_ack_i, and increment each OWNED cycle with s_stb_o high and s_ack_i low.
REQ-029 If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, SHALL enter ERROR, drive s_cyc_o/s_stb_o low, and assert m_err_o of the owner for exactly one cycle.
REQ-030 From ERROR SHALL go to IDLE next edge and advance rr_ptr as in REQ-026; a late s_ack_i in IDLE or ERROR SHALL be ignored.
REQ-031 s_ack_i arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: ack delivered, no error.
REQ-032 With NUM_MASTERS=1, SHALL behave as a pass-through with one-cycle grant latency and timeout.
REQ-033 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1; SHALL not wrap.

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, grant_o=0, rr_ptr=0, counter=0, all m_ack_o/m_err_o/s_* outputs 0 and m_data_o=0.
REQ-035 Reset deassertion mid-transaction SHALL resume from IDLE; no ack or err for the aborted cycle.

Structure
REQ-036 State enum and the default value of TIMEOUT_CYCLES SHALL live in shared package core_bus_pkg.
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out, purely combinational).

Verification
REQ-038 NUM_MASTERS=2: m_cyc_i=2'b11 from reset -> master 0 granted after 1 cycle; after it releases, master 1 granted after 1 idle cycle.
REQ-039 Master 1 holds cyc across 3 strobes at addresses 0x10, 0x14, 0x18 while master 0 requests -> grant_o=2'b10 throughout; m_ack_o[0] never high.
REQ-040 TIMEOUT_CYCLES=4, s_ack_i stuck 0 -> m_err_o[owner] pulses 1 cycle after 4 stalled cycles; s_cyc_o low; next grant goes to other master.
REQ-041 s_ack_i asserted on the 4th stalled cycle with TIMEOUT_CYCLES=4 -> m_ack_o high, m_err_o stays 0.
REQ-042 NUM_MASTERS=4, all requesting continuously with single-strobe cycles -> grant order 0,1,2,3,0; read data 0xCAFEBABE appears on m_data_o with ack.
REQ-043 rst_n pulsed low during OWNED -> all outputs 0 immediately; after release, arbitration restarts at master 0.
